// File: rtl/fft_pkg.sv
// Shared definitions for the FFT front-end blocks: frame length helper,
// bit-reversal of sample indices and the writer/reader state encodings.
package fft_pkg;

    typedef enum logic {
        WR_FILL = 1'b0,
        WR_PAD  = 1'b1
    } wr_state_e;

    typedef enum logic {
        RD_IDLE = 1'b0,
        RD_RUN  = 1'b1
    } rd_state_e;

    function automatic int fft_max(input int step);
        return 1 << step;
    endfunction

    // Reverses the low 'step' bits of a; upper bits are returned as zero.
    function automatic logic [15:0] bitrev(input logic [15:0] a, input int step);
        logic [15:0] r;
        r = '0;
        for (int i = 0; i < step; i++) begin
            r[i] = a[step-1-i];
        end
        return r;
    endfunction

endpackage

// File: rtl/fft_pingpong_ram.sv
// Two-bank simple dual-port RAM: one write port, one registered read port.
// The read register holds its value while no read is requested.
module fft_pingpong_ram #(
    parameter int WIDTH = 32,
    parameter int AW    = 5
) (
    input  logic             clk_i,
    input  logic             rst_n_i,
    input  logic             we_i,
    input  logic             wbank_i,
    input  logic [AW-1:0]    waddr_i,
    input  logic [WIDTH-1:0] wdata_i,
    input  logic             re_i,
    input  logic             rbank_i,
    input  logic [AW-1:0]    raddr_i,
    output logic [WIDTH-1:0] rdata_o
);
    localparam int DEPTH = 2 * (1 << AW);

    logic [WIDTH-1:0] mem_q [0:DEPTH-1];
    logic [WIDTH-1:0] rdata_q;

    always_ff @(posedge clk_i) begin
        if (we_i) begin
            mem_q[{wbank_i, waddr_i}] <= wdata_i;
        end
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            rdata_q <= '0;
        end else if (re_i) begin
            rdata_q <= mem_q[{rbank_i, raddr_i}];
        end
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/fft_frame_feeder.sv
// Collects a ready/valid sample stream into ping-pong frames of FFT_MAX
// samples and replays each full frame as a gap-free burst for the FFT core.
module fft_frame_feeder
    import fft_pkg::*;
#(
    parameter int DATA_WIDTH = 16,
    parameter int TOTAL_STEP = 5,
    parameter int ORDERING   = 0,
    parameter int PAD_EN     = 1
) (
    input  logic                  iclk,
    input  logic                  rstn,
    input  logic                  ivalid,
    output logic                  iready,
    input  logic [DATA_WIDTH-1:0] iReal,
    input  logic [DATA_WIDTH-1:0] iImag,
    input  logic                  ilast,
    input  logic                  imode,
    output logic                  oen,
    output logic [DATA_WIDTH-1:0] oReal,
    output logic [DATA_WIDTH-1:0] oImag,
    output logic                  ofirst,
    output logic                  olast,
    output logic                  omode,
    output logic [15:0]           oframe,
    output logic                  err_missing,
    output logic                  err_short
);
    localparam int FFT_MAX = fft_max(TOTAL_STEP);
    localparam int AW      = TOTAL_STEP;
    localparam int SW      = 2 * DATA_WIDTH;
    localparam logic [AW-1:0] LAST_IDX = AW'(FFT_MAX - 1);

    wr_state_e       wr_state_q;
    logic            wr_bank_q;
    logic [AW-1:0]   wr_cnt_q;
    logic [1:0]      full_q, full_d;
    logic [1:0]      mode_q;
    rd_state_e       rd_state_q;
    logic            rd_bank_q;
    logic [AW-1:0]   rd_cnt_q;
    logic            oen_q, ofirst_q, olast_q, omode_q;
    logic [15:0]     oframe_q;
    logic            err_missing_q, err_short_q;

    logic            accept, pad_wr, wr_we, wr_done, rd_issue, rd_done;
    logic [SW-1:0]   wr_data, rd_data;
    logic [AW-1:0]   rd_addr;
    logic [15:0]     rd_rev;

    assign iready   = ~full_q[wr_bank_q] & (wr_state_q == WR_FILL);
    assign accept   = ivalid & iready;
    assign pad_wr   = (wr_state_q == WR_PAD);
    assign wr_we    = accept | pad_wr;
    assign wr_done  = wr_we & (wr_cnt_q == LAST_IDX);
    assign wr_data  = pad_wr ? '0 : {iReal, iImag};
    assign rd_issue = (rd_state_q == RD_RUN);
    assign rd_done  = rd_issue & (rd_cnt_q == LAST_IDX);
    assign rd_rev   = bitrev(16'(rd_cnt_q), TOTAL_STEP);
    assign rd_addr  = (ORDERING != 0) ? rd_rev[AW-1:0] : rd_cnt_q;

    // Writer only completes an empty bank and reader only frees a full one,
    // so the set and clear can never target the same bank in one cycle.
    always_comb begin
        full_d = full_q;
        if (wr_done) full_d[wr_bank_q] = 1'b1;
        if (rd_done) full_d[rd_bank_q] = 1'b0;
    end

    always_ff @(posedge iclk or negedge rstn) begin
        if (!rstn) begin
            full_q <= '0;
        end else begin
            full_q <= full_d;
        end
    end

    always_ff @(posedge iclk or negedge rstn) begin
        if (!rstn) begin
            wr_state_q    <= WR_FILL;
            wr_bank_q     <= 1'b0;
            wr_cnt_q      <= '0;
            mode_q        <= '0;
            err_missing_q <= 1'b0;
            err_short_q   <= 1'b0;
        end else begin
            err_missing_q <= 1'b0;
            err_short_q   <= 1'b0;
            case (wr_state_q)
                WR_FILL: begin
                    if (accept) begin
                        if (wr_cnt_q == '0) mode_q[wr_bank_q] <= imode;
                        if (wr_cnt_q == LAST_IDX) begin
                            err_missing_q <= ~ilast;
                        end else if (ilast) begin
                            err_short_q <= 1'b1;
                            if (PAD_EN != 0) wr_state_q <= WR_PAD;
                        end
                    end
                end
                WR_PAD: begin
                    if (wr_cnt_q == LAST_IDX) wr_state_q <= WR_FILL;
                end
                default: wr_state_q <= WR_FILL;
            endcase
            if (wr_we)   wr_cnt_q  <= wr_cnt_q + 1'b1;
            if (wr_done) wr_bank_q <= ~wr_bank_q;
        end
    end

    always_ff @(posedge iclk or negedge rstn) begin
        if (!rstn) begin
            rd_state_q <= RD_IDLE;
            rd_bank_q  <= 1'b0;
            rd_cnt_q   <= '0;
            oen_q      <= 1'b0;
            ofirst_q   <= 1'b0;
            olast_q    <= 1'b0;
            omode_q    <= 1'b0;
            oframe_q   <= '0;
        end else begin
            oen_q    <= rd_issue;
            ofirst_q <= rd_issue & (rd_cnt_q == '0);
            olast_q  <= rd_done;
            if (rd_issue && (rd_cnt_q == '0)) omode_q <= mode_q[rd_bank_q];
            if (olast_q) oframe_q <= oframe_q + 1'b1;
            case (rd_state_q)
                RD_IDLE: begin
                    if (full_q[rd_bank_q]) begin
                        rd_state_q <= RD_RUN;
                        rd_cnt_q   <= '0;
                    end
                end
                RD_RUN: begin
                    rd_cnt_q <= rd_cnt_q + 1'b1;
                    if (rd_done) begin
                        rd_bank_q <= ~rd_bank_q;
                        if (!full_q[~rd_bank_q]) rd_state_q <= RD_IDLE;
                    end
                end
                default: rd_state_q <= RD_IDLE;
            endcase
        end
    end

    fft_pingpong_ram #(
        .WIDTH (SW),
        .AW    (AW)
    ) u_ram (
        .clk_i   (iclk),
        .rst_n_i (rstn),
        .we_i    (wr_we),
        .wbank_i (wr_bank_q),
        .waddr_i (wr_cnt_q),
        .wdata_i (wr_data),
        .re_i    (rd_issue),
        .rbank_i (rd_bank_q),
        .raddr_i (rd_addr),
        .rdata_o (rd_data)
    );

    assign oen         = oen_q;
    assign oReal       = rd_data[SW-1:DATA_WIDTH];
    assign oImag       = rd_data[DATA_WIDTH-1:0];
    assign ofirst      = ofirst_q;
    assign olast       = olast_q;
    assign omode       = omode_q;
    assign oframe      = oframe_q;
    assign err_missing = err_missing_q;
    assign err_short   = err_short_q;

endmodule

// File: tb/tb_fft_frame_feeder.sv
// Scoreboard bench: a natural-order and a bit-reversed instance share one
// input stream; a frame-level model predicts every emitted sample.
module tb_fft_frame_feeder;
    localparam int DW = 16;
    localparam int TS = 5;
    localparam int N  = 32;

    typedef struct packed {
        logic                mode;
        logic [N-1:0][2*DW-1:0] d;
    } frame_t;

    logic          iclk = 1'b0;
    logic          rstn = 1'b0;
    logic          ivalid = 1'b0, ilast = 1'b0, imode = 1'b0;
    logic [DW-1:0] iReal = '0, iImag = '0;

    logic          iready_w [2];
    logic          oen_w    [2];
    logic [DW-1:0] ore_w    [2];
    logic [DW-1:0] oim_w    [2];
    logic          ofirst_w [2];
    logic          olast_w  [2];
    logic          omode_w  [2];
    logic [15:0]   oframe_w [2];
    logic          emiss_w  [2];
    logic          eshort_w [2];

    always #5 iclk = ~iclk;

    fft_frame_feeder #(.DATA_WIDTH(DW), .TOTAL_STEP(TS), .ORDERING(0), .PAD_EN(1)) u_nat (
        .iclk(iclk), .rstn(rstn), .ivalid(ivalid), .iready(iready_w[0]),
        .iReal(iReal), .iImag(iImag), .ilast(ilast), .imode(imode),
        .oen(oen_w[0]), .oReal(ore_w[0]), .oImag(oim_w[0]), .ofirst(ofirst_w[0]),
        .olast(olast_w[0]), .omode(omode_w[0]), .oframe(oframe_w[0]),
        .err_missing(emiss_w[0]), .err_short(eshort_w[0]));

    fft_frame_feeder #(.DATA_WIDTH(DW), .TOTAL_STEP(TS), .ORDERING(1), .PAD_EN(1)) u_rev (
        .iclk(iclk), .rstn(rstn), .ivalid(ivalid), .iready(iready_w[1]),
        .iReal(iReal), .iImag(iImag), .ilast(ilast), .imode(imode),
        .oen(oen_w[1]), .oReal(ore_w[1]), .oImag(oim_w[1]), .ofirst(ofirst_w[1]),
        .olast(olast_w[1]), .omode(omode_w[1]), .oframe(oframe_w[1]),
        .err_missing(emiss_w[1]), .err_short(eshort_w[1]));

    int n_chk = 0, n_pass = 0;
    int cyc = 0;
    int pad_lo = 1, pad_hi = 0;
    frame_t q0[$], q1[$];
    frame_t cur = '0;
    int cur_len = 0, exp_short = 0, exp_miss = 0, exp_frames = 0;
    int idx[2], nfr[2], nmiss[2], nshort[2], run[2];
    int maxrun = 0;

    always @(posedge iclk) cyc <= cyc + 1;

    task automatic check(input string name, input longint act, input longint exp);
        n_chk++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    endtask

    function automatic int brev(input int k);
        int r;
        r = 0;
        for (int i = 0; i < TS; i++) r = r | (((k >> i) & 1) << (TS - 1 - i));
        return r;
    endfunction

    // Frame model: a frame closes at N samples or at an early marker (then zero-filled).
    task automatic model_accept(input logic [DW-1:0] re, input logic [DW-1:0] im,
                                input logic last, input logic mode, output int pads);
        pads = 0;
        if (cur_len == 0) cur.mode = mode;
        cur.d[cur_len] = {re, im};
        cur_len++;
        if (cur_len == N || last) begin
            if (cur_len == N && !last) exp_miss++;
            if (cur_len < N) begin
                exp_short++;
                pads = N - cur_len;
                for (int i = cur_len; i < N; i++) cur.d[i] = '0;
            end
            q0.push_back(cur);
            q1.push_back(cur);
            exp_frames++;
            cur_len = 0;
            cur = '0;
        end
    endtask

    task automatic send(input logic [DW-1:0] re, input logic [DW-1:0] im,
                        input logic last, input logic mode, output int waited);
        int pads;
        @(negedge iclk);
        ivalid = 1'b1; iReal = re; iImag = im; ilast = last; imode = mode;
        waited = 0;
        while (!iready_w[0] && waited < 500) begin
            @(negedge iclk);
            waited++;
        end
        if (!iready_w[0]) begin
            check("accept_timeout", 0, 1);
            ivalid = 1'b0;
            return;
        end
        model_accept(re, im, last, mode, pads);
        @(posedge iclk);
        #1;
        if (pads > 0) begin
            pad_lo = cyc;
            pad_hi = cyc + pads - 1;
        end
    endtask

    task automatic idle();
        @(negedge iclk);
        ivalid = 1'b0;
        ilast  = 1'b0;
    endtask

    task automatic drain();
        int t;
        t = 0;
        while ((q0.size() != 0 || q1.size() != 0) && t < 2000) begin
            @(negedge iclk);
            t++;
        end
        check("drain_done", longint'(q0.size() + q1.size()), 0);
        repeat (4) @(negedge iclk);
    endtask

    // Monitor: compares each presented output sample against the scoreboard.
    always @(negedge iclk) begin
        if (!rstn) begin
            for (int d = 0; d < 2; d++) begin
                idx[d] = 0; nfr[d] = 0; nmiss[d] = 0; nshort[d] = 0; run[d] = 0;
            end
            q0.delete();
            q1.delete();
        end else begin
            check("iready_match", iready_w[1], iready_w[0]);
            if (cyc >= pad_lo && cyc <= pad_hi) check("pad_iready_low", iready_w[0], 0);
            for (int d = 0; d < 2; d++) begin
                frame_t f;
                int     k;
                bit     got;
                string  nm;
                nm  = (d == 0) ? "nat" : "rev";
                got = 1'b0;
                f   = '0;
                if (oen_w[d]) begin
                    if (d == 0 && q0.size() > 0) begin f = q0[0]; got = 1'b1; end
                    else if (d == 1 && q1.size() > 0) begin f = q1[0]; got = 1'b1; end
                    if (!got) begin
                        check({"unexpected_oen_", nm}, 1, 0);
                    end else begin
                        k = (d == 0) ? idx[d] : brev(idx[d]);
                        check({"data_", nm}, {ore_w[d], oim_w[d]}, f.d[k]);
                        check({"ofirst_", nm}, ofirst_w[d], (idx[d] == 0));
                        check({"olast_", nm}, olast_w[d], (idx[d] == N - 1));
                        check({"omode_", nm}, omode_w[d], f.mode);
                        if (idx[d] == 0) check({"oframe_", nm}, oframe_w[d], nfr[d] % 65536);
                        idx[d]++;
                        if (idx[d] == N) begin
                            idx[d] = 0;
                            nfr[d]++;
                            if (d == 0) void'(q0.pop_front());
                            else        void'(q1.pop_front());
                        end
                    end
                    run[d]++;
                    if (d == 0 && run[d] > maxrun) maxrun = run[d];
                end else begin
                    if (idx[d] != 0) begin
                        check({"oen_gap_", nm}, 0, 1);
                        idx[d] = 0;
                        if (d == 0) void'(q0.pop_front());
                        else        void'(q1.pop_front());
                    end
                    run[d] = 0;
                end
                if (emiss_w[d])  nmiss[d]++;
                if (eshort_w[d]) nshort[d]++;
            end
        end
    end

    initial begin
        #900000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int w;
        logic last;
        // Reset values
        #12;
        for (int d = 0; d < 2; d++) begin
            check("rst_oen", oen_w[d], 0);
            check("rst_data", {ore_w[d], oim_w[d]}, 0);
            check("rst_flags", {ofirst_w[d], olast_w[d], omode_w[d], emiss_w[d], eshort_w[d]}, 0);
            check("rst_oframe", oframe_w[d], 0);
        end
        @(negedge iclk); #2 rstn = 1'b1;

        // Continuous two frames of k+0j
        for (int i = 0; i < 2 * N; i++) send(DW'(i % N), '0, (i % N) == N - 1, 1'b0, w);
        idle();
        drain();
        check("burst_run_len", maxrun, 2 * N);
        check("oframe_after_two", oframe_w[0], 2);

        // Early marker on the 20th sample: padded with zeros
        for (int i = 0; i < 20; i++) send(DW'(i + 100), DW'(i), i == 19, 1'b1, w);
        idle();
        drain();
        check("short_pulses", nshort[0], 1);

        // 32 samples without a marker, then first-output latency
        for (int i = 0; i < N; i++) send(DW'($urandom), DW'($urandom), 1'b0, 1'b0, w);
        idle();
        check("missing_pulse", emiss_w[0], 1);
        check("latency_e1", oen_w[0], 0);
        @(negedge iclk);
        check("latency_e2", oen_w[0], 0);
        @(negedge iclk);
        check("latency_e3", oen_w[0], 1);
        drain();
        check("missing_pulses", nmiss[0], 1);

        // Source faster than sink: 96 held samples
        for (int i = 0; i < 3 * N; i++) begin
            send(DW'(i), DW'(3 * N - i), (i % N) == N - 1, 1'b0, w);
            if (i == 2 * N - 1) check("no_wait_sample63", w, 0);
            if (i == 2 * N) check("wait_sample64", w, 1);
        end
        idle();
        drain();

        // Mode tagging and reset in the middle of the next frame
        for (int i = 0; i < N; i++) send(DW'($urandom), DW'($urandom), i == N - 1, (i == 0) ? 1'b1 : 1'($urandom), w);
        for (int i = 0; i < 10; i++) send(DW'($urandom), DW'($urandom), 1'b0, 1'b0, w);
        idle();
        w = 0;
        while (!oen_w[0] && w < 200) begin @(negedge iclk); w++; end
        repeat (3) @(negedge iclk);
        check("oen_before_reset", oen_w[0], 1);
        #2 rstn = 1'b0;
        #1;
        cur_len = 0; cur = '0; exp_short = 0; exp_miss = 0; exp_frames = 0;
        for (int d = 0; d < 2; d++) begin
            check("async_oen_drop", oen_w[d], 0);
            check("rst_mid_data", {ore_w[d], oim_w[d]}, 0);
            check("rst_mid_flags", {ofirst_w[d], olast_w[d], omode_w[d], emiss_w[d], eshort_w[d]}, 0);
            check("rst_mid_oframe", oframe_w[d], 0);
        end
        repeat (3) @(negedge iclk);
        #2 rstn = 1'b1;
        for (int i = 0; i < N; i++) send(DW'($urandom), DW'($urandom), i == N - 1, 1'b0, w);
        idle();
        drain();

        // Randomized traffic with gaps, short and unmarked frames
        for (int i = 0; i < 400; i++) begin
            last = (cur_len == N - 1) ? ($urandom % 4 != 0) : ($urandom % 12 == 0);
            send(DW'($urandom), DW'($urandom), last, 1'($urandom), w);
            if ($urandom % 4 == 0) repeat ($urandom % 3 + 1) idle();
        end
        idle();
        while (cur_len != 0) send(DW'($urandom), DW'($urandom), 1'b1, 1'b0, w);
        idle();
        drain();

        for (int d = 0; d < 2; d++) begin
            check("final_short_count", nshort[d], exp_short);
            check("final_missing_count", nmiss[d], exp_miss);
            check("final_frames", nfr[d], exp_frames);
            check("final_oframe", oframe_w[d], exp_frames % 65536);
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
